// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants and types for the shift arbiter slice
package shift_pkg;

    localparam int WIDTH = 32;
    localparam int SA_W  = 5;

    localparam logic ID_REQ0   = 1'b0;
    localparam logic ID_REQ1   = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SA_W-1:0]  sa;
        logic             right;
        logic             arith;
    } shift_req_t;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational 32-bit left/right/arithmetic shifter
module barrel_shifter
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] d,
    input  logic [SA_W-1:0]  sa,
    input  logic             right,
    input  logic             arith,
    output logic [WIDTH-1:0] sh
);

    always_comb begin
        sh = d;
        if (right == DIR_LEFT) begin
            sh = d << sa;
        end else if (arith) begin
            sh = $unsigned($signed(d) >>> sa);
        end else begin
            sh = d >> sa;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant logic; last_grant is held by the caller
module rr_arb2
    import shift_pkg::*;
(
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last_grant,
    output logic [1:0] grant_onehot,
    output logic       grant_id
);

    always_comb begin
        grant_id = ID_REQ0;
        case (req)
            2'b10:   grant_id = ID_REQ1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = ID_REQ0;
        endcase

        // Gating by en keeps a stalled stage from issuing (and committing) a grant.
        grant_onehot = 2'b00;
        if (en && (req != 2'b00)) begin
            grant_onehot[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two requesters share one barrel shifter; optional SHIFT_ARB_STATS_EN grant counters
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int SA_W  = shift_pkg::SA_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_d,
    input  logic [SA_W-1:0]  req0_sa,
    input  logic             req0_right,
    input  logic             req0_arith,
    input  logic [WIDTH-1:0] req1_d,
    input  logic [SA_W-1:0]  req1_sa,
    input  logic             req1_right,
    input  logic             req1_arith,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sh,
    output logic             resp_id
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    if (WIDTH != shift_pkg::WIDTH || SA_W != shift_pkg::SA_W) begin : g_bad_width
        $error("shift_arbiter: barrel_shifter supports only WIDTH=32, SA_W=5");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("shift_arbiter: CNT_W must be at least 1");
    end

    logic       accept;
    logic       last_grant;
    logic       grant_id;
    logic [1:0] grant_onehot;
    logic       handshake;
    shift_req_t sel;
    logic [WIDTH-1:0] sh;

    assign accept = !resp_valid || resp_ready;

    rr_arb2 u_arb (
        .req          (req_valid),
        .en           (accept),
        .last_grant   (last_grant),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id)
    );

    assign req_ready = grant_onehot;
    assign handshake = |grant_onehot;

    always_comb begin
        if (grant_id == ID_REQ1) begin
            sel = '{d: req1_d, sa: req1_sa, right: req1_right, arith: req1_arith};
        end else begin
            sel = '{d: req0_d, sa: req0_sa, right: req0_right, arith: req0_arith};
        end
    end

    barrel_shifter u_shift (
        .d     (sel.d),
        .sa    (sel.sa),
        .right (sel.right),
        .arith (sel.arith),
        .sh    (sh)
    );

    // resp_valid doubles as the EMPTY/FULL state of the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_sh    <= '0;
            resp_id    <= ID_REQ0;
            last_grant <= ID_REQ1;
        end else if (handshake) begin
            resp_valid <= 1'b1;
            resp_sh    <= sh;
            resp_id    <= grant_id;
            last_grant <= grant_id;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req_ready[0] && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (req_ready[1] && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational barrel_shifter (32-bit data, 5-bit shift amount, right and arith controls) between two requesters, for example the ALU path and the address-generation path.
- Round-robin arbitration with valid/ready handshakes on both request ports.
- One registered result stage with backpressure.
- Tags each result with the ID of the requester that issued it.

Parameters:
- WIDTH, 32, data width; fixed by barrel_shifter, and any other value is a configuration error.
- SA_W, 5, shift-amount width; equals log2(WIDTH).
- CNT_W, 16, width of the statistics counters; used only when SHIFT_ARB_STATS_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle, bit i = requester i.
- req0_d  in  WIDTH  requester 0 data.
- req0_sa  in  SA_W  requester 0 shift amount.
- req0_right  in  1  requester 0 direction: 1 = right, 0 = left.
- req0_arith  in  1  requester 0 arithmetic select; meaningful only for right shifts.
- req1_d, req1_sa, req1_right, req1_arith  in  same widths and meanings as requester 0.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_sh  out  WIDTH  shifted result.
- resp_id  out  1  ID of the requester that produced resp_sh.
- grant_cnt0, grant_cnt1  out  CNT_W  per-requester grant counts; present only with SHIFT_ARB_STATS_EN.

Behaviour:
Reset values:
- resp_valid=0, resp_sh=0, resp_id=0.
- last_grant=1, so requester 0 wins the first contested cycle.
- Counters=0.

Stage enable:
- accept = !resp_valid || resp_ready.
- With one request valid and accept=1: grant that requester.
- With both requests valid and accept=1: grant the requester that is not last_grant, then set last_grant to the granted ID.
- req_ready[i] = accept && (grant==i). This is combinational from req_valid, resp_valid and resp_ready.
- req_ready is never asserted for a requester whose req_valid is 0.
- With no request valid, last_grant is unchanged.

Datapath:
- The mux selects the granted requester's {d, sa, right, arith} and drives the shared barrel_shifter.
- Shifter semantics:
  - right=0: logical left shift, arith ignored.
  - right=1, arith=0: logical right shift.
  - right=1, arith=1: arithmetic right shift (sign-filled).
- sa=0 passes data through unchanged.

Registering and latency:
- On a handshake in cycle N, the result register loads {sh, grant} at the edge closing cycle N.
- resp_valid is high from cycle N+1, so latency is 1 cycle.
- Throughput is 1 result per cycle while resp_ready=1.

Result register control (two states, EMPTY and FULL, encoded by resp_valid):

| Current state | Condition | Action / next state |
|---|---|---|
| EMPTY | any handshake | FULL |
| FULL | resp_ready=1 and new handshake | reload, stay FULL (back-to-back) |
| FULL | resp_ready=1 and no handshake | EMPTY |
| FULL | resp_ready=0 | hold resp_sh and resp_id stable; req_ready=0 for both requesters |

Boundary conditions:
- Simultaneous requests under backpressure: no grant is issued and last_grant does not advance. Fairness is preserved when the stall releases.
- Request inputs may change while req_ready=0; only the values present at the handshake are used.
- Reset mid-operation: any pending result is discarded without a handshake and all state returns to reset values. A requester that was stalled must re-present its request.
- Starvation bound: a continuously valid requester is granted within 2 accept cycles.

Optional Feature:
Macro SHIFT_ARB_STATS_EN.
- Defined:
  - grant_cnt0 and grant_cnt1 ports exist.
  - Each counter increments by 1 on every handshake of its requester.
  - Counters saturate at all-ones.
  - rst clears them.
- Undefined:
  - The ports and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package/header shift_pkg:
  - WIDTH and SA_W constants.
  - Requester ID constants: ID_REQ0=0, ID_REQ1=1.
  - Direction encodings: DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module rr_arb2:
  - Inputs: req[1:0], en, last_grant.
  - Outputs: grant_onehot[1:0], grant_id.
  - Purely combinational; the last_grant register stays in shift_arbiter.
- barrel_shifter is instantiated once, unmodified.

Test Plan:
1. Single request, left shift: req0 only, d=FF0000FF, sa=8, right=0, arith=0, resp_ready=1. Required: req_ready=01 in cycle 0; in cycle 1 resp_valid=1, resp_sh=0000FF00, resp_id=0.
2. Logical vs arithmetic right shift: same d and sa with right=1. arith=0 gives resp_sh=00FF0000; arith=1 gives resp_sh=FFFF0000; sa=0 gives FF0000FF.
3. Round-robin: both requesters valid continuously, req1 d=00000001, sa=4, left; resp_ready=1. Required: grants alternate 0,1,0,1 starting with 0; req1 results are 00000010; back-to-back resp_valid with no bubbles.
4. Backpressure: after a result is registered, hold resp_ready=0 for 3 cycles with both requesters valid. Required: req_ready=00 throughout and resp_sh/resp_id stable. On release, the next grant goes to the requester that did not produce the held result.
5. Reset mid-operation: assert rst for 1 cycle while resp_valid=1 and resp_ready=0. Required: next cycle resp_valid=0, resp_sh=0, resp_id=0; the first contested grant afterwards goes to requester 0.
6. Statistics (SHIFT_ARB_STATS_EN, CNT_W forced to 2): 5 req0 handshakes. Required: grant_cnt0 reads 1,2,3,3,3 and grant_cnt1 stays 0. Without the macro the design must compile, and results from scenarios 1-5 must be identical.
